// File: rtl/fp_block_accumulator.sv
// ============================================================================
// Module   : fp_block_accumulator (with lane core: adder)
// Summary  : LANES-wide IEEE-754 single-precision block accumulator with a
//            valid/ready input, a clear/load mode and a saturating beat count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Multi-cycle single-precision adder: unpack, align, add, normalise/round.
module adder (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] Number1,
  input  logic [31:0] Number2,
  input  logic        result_ack,
  output logic        result_ready,
  output logic [31:0] Result
);

  typedef enum logic [2:0] {
    A_IDLE  = 3'd0,
    A_ALIGN = 3'd1,
    A_ADD   = 3'd2,
    A_NORM  = 3'd3,
    A_DONE  = 3'd4
  } astate_t;

  astate_t r_state, w_next;

  logic        w_swap, w_nan, w_inf_cancel;
  logic [31:0] w_big, w_small, w_spec_val;
  logic [7:0]  w_big_e, w_small_e;

  logic        r_sa, r_sb, r_spec;
  logic [31:0] r_spec_val, r_res;
  logic [7:0]  r_ea, r_eb;
  logic [26:0] r_ma, r_mb;
  logic [27:0] r_sum;

  logic [7:0]  w_d;
  logic        w_far;
  logic [26:0] w_mask, w_shr, w_mb_al;

  logic [4:0]  w_lz, w_sh;
  logic [9:0]  w_e;
  logic [26:0] w_m;
  logic        w_inc;
  logic [24:0] w_rnd;
  logic [23:0] w_mant;
  logic [31:0] w_norm;

  // Larger magnitude always goes to operand A so the subtraction never wraps.
  assign w_swap       = Number2[30:0] > Number1[30:0];
  assign w_big        = w_swap ? Number2 : Number1;
  assign w_small      = w_swap ? Number1 : Number2;
  assign w_big_e      = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
  assign w_small_e    = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
  assign w_nan        = (w_big[30:23] == 8'hFF) && (w_big[22:0] != 23'd0);
  assign w_inf_cancel = (w_big[30:23] == 8'hFF) && (w_small[30:0] == w_big[30:0])
                        && (w_small[31] != w_big[31]);
  assign w_spec_val   = (w_nan || w_inf_cancel) ? 32'h7FC0_0000 : w_big;

  assign w_d     = r_ea - r_eb;
  assign w_far   = w_d >= 8'd27;
  assign w_mask  = w_far ? {27{1'b1}} : ((27'd1 << w_d) - 27'd1);
  assign w_shr   = w_far ? 27'd0 : (r_mb >> w_d);
  assign w_mb_al = {w_shr[26:1], w_shr[0] | (|(r_mb & w_mask))};

  always_comb begin
    w_lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (r_sum[i]) w_lz = 5'(26 - i);
    end
  end

  // Normalise (left shift limited to keep exponent >= 1 for subnormals), then RNE.
  always_comb begin
    w_e    = {2'b00, r_ea};
    w_m    = r_sum[26:0];
    w_sh   = 5'd0;
    w_inc  = 1'b0;
    w_rnd  = 25'd0;
    w_mant = 24'd0;
    w_norm = 32'd0;
    if (r_sum[27]) begin
      w_m = {r_sum[27:2], r_sum[1] | r_sum[0]};
      w_e = w_e + 10'd1;
    end else begin
      if ({5'd0, w_lz} > (w_e - 10'd1)) w_sh = w_e[4:0] - 5'd1;
      else                              w_sh = w_lz;
      w_m = r_sum[26:0] << w_sh;
      w_e = w_e - {5'd0, w_sh};
    end
    w_inc = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
    w_rnd = {1'b0, w_m[26:3]} + {24'd0, w_inc};
    if (w_rnd[24]) begin
      w_mant = w_rnd[24:1];
      w_e    = w_e + 10'd1;
    end else begin
      w_mant = w_rnd[23:0];
    end
    if (w_e >= 10'd255)   w_norm = {r_sa, 8'hFF, 23'd0};
    else if (!w_mant[23]) w_norm = {r_sa, 8'd0, w_mant[22:0]};
    else                  w_norm = {r_sa, w_e[7:0], w_mant[22:0]};
    if (r_sum == 28'd0)   w_norm = {r_sa & r_sb, 31'd0};
    if (r_spec)           w_norm = r_spec_val;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      A_IDLE:  if (load) w_next = A_ALIGN;
      A_ALIGN: w_next = A_ADD;
      A_ADD:   w_next = A_NORM;
      A_NORM:  w_next = A_DONE;
      A_DONE:  if (result_ack) w_next = A_IDLE;
      default: w_next = A_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= A_IDLE;
      r_res   <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == A_NORM) r_res <= w_norm;
    end
  end

  always_ff @(posedge clk) begin
    case (r_state)
      A_IDLE: begin
        r_sa       <= w_big[31];
        r_sb       <= w_small[31];
        r_ea       <= w_big_e;
        r_eb       <= w_small_e;
        r_ma       <= {(w_big[30:23] != 8'd0), w_big[22:0], 3'b000};
        r_mb       <= {(w_small[30:23] != 8'd0), w_small[22:0], 3'b000};
        r_spec     <= (w_big[30:23] == 8'hFF);
        r_spec_val <= w_spec_val;
      end
      A_ALIGN: r_mb <= w_mb_al;
      A_ADD:   r_sum <= (r_sa == r_sb) ? ({1'b0, r_ma} + {1'b0, r_mb})
                                       : ({1'b0, r_ma} - {1'b0, r_mb});
      default: ;
    endcase
  end

  assign result_ready = (r_state == A_DONE);
  assign Result       = r_res;

endmodule

// Lane-parallel accumulator wrapper around one adder per lane.
module fp_block_accumulator #(
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_clear,
  input  logic [LANES*32-1:0]   in_data,
  output logic [LANES*32-1:0]   acc_data,
  output logic [CNT_W-1:0]      beats,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_ADD   = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [LANES*32-1:0] r_acc, r_opnd, w_result;
  logic [CNT_W-1:0]    r_beats;
  logic                r_done;
  logic [LANES-1:0]    w_lane_ready;
  logic                w_xfer, w_all_ready, w_capture, w_result_ack, w_adder_rst;

  assign in_ready     = (r_state == S_IDLE);
  assign w_xfer       = in_valid && in_ready;
  assign w_all_ready  = &w_lane_ready;
  assign w_capture    = (r_state == S_ADD) && w_all_ready;
  assign w_result_ack = (r_state == S_SETUP);
  // Adders run only from SETUP up to the capture edge; the capture returns to IDLE.
  assign w_adder_rst  = reset || (r_state == S_IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer && !in_clear) w_next = S_SETUP;
      S_SETUP: w_next = S_ADD;
      S_ADD:   if (w_all_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_beats <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (w_xfer && in_clear) begin
        r_acc   <= in_data;
        r_beats <= CNT_W'(1);
        r_done  <= 1'b1;
      end
      if (w_capture) begin
        r_acc   <= w_result;
        r_beats <= (r_beats == {CNT_W{1'b1}}) ? r_beats : r_beats + CNT_W'(1);
        r_done  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer && !in_clear) r_opnd <= in_data;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    adder u_adder (
      .clk          (clk),
      .reset        (w_adder_rst),
      .load         (1'b1),
      .Number1      (r_acc[g*32 +: 32]),
      .Number2      (r_opnd[g*32 +: 32]),
      .result_ack   (w_result_ack),
      .result_ready (w_lane_ready[g]),
      .Result       (w_result[g*32 +: 32])
    );
  end

  assign acc_data = r_acc;
  assign beats    = r_beats;
  assign done     = r_done;

endmodule

`default_nettype wire
